// File: rtl/dds_sweep_ctrl_if.sv
// Sweep-controller bus: configuration and start/stop in, frequency word and status out.
interface dds_sweep_ctrl_if #(
    parameter int N  = 24,
    parameter int DW = 16
);
    logic          start;
    logic          stop;
    logic          mode;
    logic [N-1:0]  f_start;
    logic [N-1:0]  f_stop;
    logic [N-1:0]  f_step;
    logic [DW-1:0] dwell;
    logic [N-1:0]  FreqWord;
    logic          busy;
    logic          step_tick;
    logic          done;

    modport master (
        output start, stop, mode, f_start, f_stop, f_step, dwell,
        input  FreqWord, busy, step_tick, done
    );

    modport slave (
        input  start, stop, mode, f_start, f_stop, f_step, dwell,
        output FreqWord, busy, step_tick, done
    );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep controller driving the DDS frequency word.
// Single up-sweep or continuous triangle sweep with a per-value dwell time.
module dds_sweep_ctrl #(
    parameter int N  = 24,
    parameter int DW = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    dds_sweep_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        UP,
        DOWN
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  freq_q, freq_d;
    logic          busy_q, busy_d;
    logic          tick_q, tick_d;
    logic          done_q, done_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  fstart_q, fstart_d;
    logic [N-1:0]  fstop_q, fstop_d;
    logic [N-1:0]  fstep_q, fstep_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic          mode_q, mode_d;

    // Widened arithmetic so a step past either end is caught before it wraps.
    logic [N:0]    up_sum;
    logic [N:0]    dn_diff;
    logic [N-1:0]  up_clamped;
    logic [N-1:0]  dn_clamped;
    logic          end_dwell;

    // Clamped next-up / next-down values and end-of-dwell detection.
    always_comb begin
        up_sum     = {1'b0, freq_q} + {1'b0, fstep_q};
        dn_diff    = {1'b0, freq_q} - {1'b0, fstep_q};
        up_clamped = (up_sum > {1'b0, fstop_q}) ? fstop_q : up_sum[N-1:0];
        dn_clamped = (dn_diff[N] || (dn_diff[N-1:0] < fstart_q)) ? fstart_q : dn_diff[N-1:0];
        end_dwell  = (cnt_q == (dwell_q - 1'b1));
    end

    // Next-state and output logic for the sweep FSM.
    always_comb begin
        state_d  = state_q;
        freq_d   = freq_q;
        busy_d   = busy_q;
        tick_d   = 1'b0;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        fstart_d = fstart_q;
        fstop_d  = fstop_q;
        fstep_d  = fstep_q;
        dwell_d  = dwell_q;
        mode_d   = mode_q;

        if (bus.stop) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        fstart_d = bus.f_start;
                        fstop_d  = bus.f_stop;
                        fstep_d  = bus.f_step;
                        dwell_d  = (bus.dwell == '0) ? {{(DW-1){1'b0}}, 1'b1} : bus.dwell;
                        mode_d   = bus.mode;
                        freq_d   = bus.f_start;
                        if ((bus.f_step == '0) || (bus.f_stop <= bus.f_start)) begin
                            done_d = 1'b1;
                        end else begin
                            cnt_d   = '0;
                            busy_d  = 1'b1;
                            state_d = UP;
                        end
                    end
                end
                UP: begin
                    cnt_d = end_dwell ? '0 : cnt_q + 1'b1;
                    if (end_dwell) begin
                        if (freq_q < fstop_q) begin
                            freq_d = up_clamped;
                            tick_d = 1'b1;
                        end else if (!mode_q) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = DOWN;
                            freq_d  = dn_clamped;
                            tick_d  = 1'b1;
                        end
                    end
                end
                DOWN: begin
                    cnt_d = end_dwell ? '0 : cnt_q + 1'b1;
                    if (end_dwell) begin
                        if (freq_q > fstart_q) begin
                            freq_d = dn_clamped;
                        end else begin
                            state_d = UP;
                            freq_d  = up_clamped;
                        end
                        tick_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            freq_q   <= '0;
            busy_q   <= 1'b0;
            tick_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            fstart_q <= '0;
            fstop_q  <= '0;
            fstep_q  <= '0;
            dwell_q  <= {{(DW-1){1'b0}}, 1'b1};
            mode_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            freq_q   <= freq_d;
            busy_q   <= busy_d;
            tick_q   <= tick_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            fstart_q <= fstart_d;
            fstop_q  <= fstop_d;
            fstep_q  <= fstep_d;
            dwell_q  <= dwell_d;
            mode_q   <= mode_d;
        end
    end

    assign bus.FreqWord  = freq_q;
    assign bus.busy      = busy_q;
    assign bus.step_tick = tick_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: elapsed-time reference model plus directed literal checks.
module tb_dds_sweep_ctrl;
    localparam int N  = 24;
    localparam int DW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    dds_sweep_ctrl_if #(.N(N), .DW(DW)) bus ();
    dds_sweep_ctrl #(.N(N), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the sweep is a precomputed list of values, each shown for D cycles.
    longint        m_seq[$];
    bit            m_active = 1'b0;
    bit            m_mode   = 1'b0;
    int            m_t      = 0;
    int            m_d      = 1;
    logic [N-1:0]  e_freq   = '0;
    bit            e_busy   = 1'b0;
    bit            e_tick   = 1'b0;
    bit            e_done   = 1'b0;

    function automatic void build_seq(input longint fs, input longint fe, input longint st, input bit tri_m);
        longint v;
        bit up;
        m_seq.delete();
        v = fs;
        m_seq.push_back(v);
        if (!tri_m) begin
            while (v < fe) begin
                v = (v + st > fe) ? fe : v + st;
                m_seq.push_back(v);
            end
        end else begin
            up = 1'b1;
            while (m_seq.size() < 400) begin
                if (up) begin
                    if (v < fe) v = (v + st > fe) ? fe : v + st;
                    else begin up = 1'b0; v = (fe - st < fs) ? fs : fe - st; end
                end else begin
                    if (v > fs) v = (v - st < fs) ? fs : v - st;
                    else begin up = 1'b1; v = (fs + st > fe) ? fe : fs + st; end
                end
                m_seq.push_back(v);
            end
        end
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_active = 1'b0; e_freq = '0; e_busy = 1'b0; e_tick = 1'b0; e_done = 1'b0;
            end else begin
                e_tick = 1'b0;
                e_done = 1'b0;
                if (bus.stop) begin
                    m_active = 1'b0;
                    e_busy   = 1'b0;
                end else if (!m_active) begin
                    if (bus.start) begin
                        e_freq = bus.f_start;
                        if (bus.f_step == 0 || bus.f_stop <= bus.f_start) begin
                            e_done = 1'b1;
                        end else begin
                            build_seq(longint'(bus.f_start), longint'(bus.f_stop), longint'(bus.f_step), bus.mode);
                            m_mode   = bus.mode;
                            m_d      = (bus.dwell == 0) ? 1 : int'(bus.dwell);
                            m_t      = 0;
                            m_active = 1'b1;
                            e_busy   = 1'b1;
                        end
                    end
                end else begin
                    int idx;
                    m_t++;
                    idx = m_t / m_d;
                    if (!m_mode && idx >= m_seq.size()) begin
                        m_active = 1'b0;
                        e_busy   = 1'b0;
                        e_done   = 1'b1;
                    end else begin
                        if (idx >= m_seq.size()) idx = m_seq.size() - 1;
                        e_freq = N'(m_seq[idx]);
                        e_tick = (m_t % m_d == 0);
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("model_freq", 64'(bus.FreqWord), 64'(e_freq));
                chk("model_busy", 64'(bus.busy), 64'(e_busy));
                chk("model_tick", 64'(bus.step_tick), 64'(e_tick));
                chk("model_done", 64'(bus.done), 64'(e_done));
            end
        end
    end

    task automatic do_start(input logic [N-1:0] fs, input logic [N-1:0] fe, input logic [N-1:0] st,
                            input logic [DW-1:0] dw, input logic md, input logic stp);
        @(posedge clk); #2;
        bus.f_start = fs; bus.f_stop = fe; bus.f_step = st; bus.dwell = dw; bus.mode = md;
        bus.start = 1'b1; bus.stop = stp;
        @(posedge clk); #2;
        bus.start = 1'b0; bus.stop = 1'b0;
    endtask

    task automatic measure(input int budget, input bit inject, output int bcnt, output int tcnt,
                           output int dcnt, output logic [N-1:0] first, output logic [N-1:0] last);
        bcnt = 0; tcnt = 0; dcnt = 0; first = '0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (i == 0) first = bus.FreqWord;
            if (bus.busy) bcnt++;
            if (bus.step_tick) tcnt++;
            if (bus.done) dcnt++;
            if (inject && i == 4) begin
                bus.start = 1'b1; bus.f_start = 5; bus.f_stop = 9; bus.f_step = 1; bus.dwell = 1;
            end
            if (inject && i == 5) bus.start = 1'b0;
            if (bus.done) break;
        end
        last = bus.FreqWord;
    endtask

    int           bc, tc, dc;
    logic [N-1:0] fv, lv, hold;
    logic [N-1:0] tri_exp [12];
    logic [N-1:0] fs, fe, st;
    longint       span;

    initial begin
        bus.start = 0; bus.stop = 0; bus.mode = 0;
        bus.f_start = '0; bus.f_stop = '0; bus.f_step = '0; bus.dwell = '0;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_freq", 64'(bus.FreqWord), 64'd0);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_tick", 64'(bus.step_tick), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        cmp_en = 1'b1;
        @(posedge clk); #2 rst_n = 1'b1;

        // Single sweep 100..130 step 10, dwell 3
        do_start(100, 130, 10, 3, 0, 0);
        measure(100, 0, bc, tc, dc, fv, lv);
        chk("single_first", 64'(fv), 64'd100);
        chk("single_busy_cycles", 64'(bc), 64'd12);
        chk("single_ticks", 64'(tc), 64'd3);
        chk("single_done", 64'(dc), 64'd1);
        chk("single_last", 64'(lv), 64'd130);
        repeat (3) @(negedge clk);
        chk("single_hold", 64'(bus.FreqWord), 64'd130);

        // Clamp to 125 with dwell 0 treated as 1
        do_start(100, 125, 10, 0, 0, 0);
        measure(100, 0, bc, tc, dc, fv, lv);
        chk("clamp_busy_cycles", 64'(bc), 64'd4);
        chk("clamp_ticks", 64'(tc), 64'd3);
        chk("clamp_done", 64'(dc), 64'd1);
        chk("clamp_last", 64'(lv), 64'd125);

        // Overflow at the top of the word range
        do_start(24'hFFFFF0, 24'hFFFFFF, 24'h10, 1, 0, 0);
        measure(100, 0, bc, tc, dc, fv, lv);
        chk("ovf_first", 64'(fv), 64'hFFFFF0);
        chk("ovf_busy_cycles", 64'(bc), 64'd2);
        chk("ovf_last", 64'(lv), 64'hFFFFFF);

        // Degenerate step of zero
        do_start(50, 90, 0, 2, 0, 0);
        measure(5, 0, bc, tc, dc, fv, lv);
        chk("degen_busy", 64'(bc), 64'd0);
        chk("degen_done", 64'(dc), 64'd1);
        chk("degen_freq", 64'(lv), 64'd50);

        // start and stop together: nothing starts
        do_start(10, 90, 5, 2, 0, 1);
        measure(5, 0, bc, tc, dc, fv, lv);
        chk("conflict_busy", 64'(bc), 64'd0);
        chk("conflict_done", 64'(dc), 64'd0);

        // start while busy is ignored
        do_start(100, 130, 10, 3, 0, 0);
        measure(100, 1, bc, tc, dc, fv, lv);
        chk("rebusy_busy_cycles", 64'(bc), 64'd12);
        chk("rebusy_done", 64'(dc), 64'd1);
        chk("rebusy_last", 64'(lv), 64'd130);

        // Triangle 100..120 step 10, dwell 2, then stop
        tri_exp = '{100, 100, 110, 110, 120, 120, 110, 110, 100, 100, 110, 110};
        do_start(100, 120, 10, 2, 1, 0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk($sformatf("tri_seq%0d", i), 64'(bus.FreqWord), 64'(tri_exp[i]));
        end
        @(posedge clk); #2 bus.stop = 1'b1;
        hold = bus.FreqWord;
        @(posedge clk); #2 bus.stop = 1'b0;
        chk("tri_stop_busy", 64'(bus.busy), 64'd0);
        chk("tri_stop_freq", 64'(bus.FreqWord), 64'(hold));
        repeat (4) @(posedge clk);
        #2 chk("tri_frozen", 64'(bus.FreqWord), 64'(hold));

        // Asynchronous reset mid-sweep
        do_start(100, 130, 10, 3, 0, 0);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_freq", 64'(bus.FreqWord), 64'd0);
        chk("async_rst_busy", 64'(bus.busy), 64'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_idle", 64'(bus.busy), 64'd0);

        // Randomized sweeps with inputs disturbed during each sweep
        for (int it = 0; it < 40; it++) begin
            int n;
            logic md;
            fs = N'($urandom);
            if ($urandom_range(0, 3) == 0) fs = 24'hFFFFFF - N'($urandom_range(0, 100));
            span = longint'(fs) + $urandom_range(0, 200);
            if (span > 64'hFFFFFF) span = 64'hFFFFFF;
            if ($urandom_range(0, 9) == 0) span = longint'(fs) - $urandom_range(0, 20);
            if (span < 0) span = 0;
            fe = N'(span);
            st = ($urandom_range(0, 9) == 0) ? '0 : N'($urandom_range(1, 60));
            md = 1'($urandom_range(0, 1));
            do_start(fs, fe, st, DW'($urandom_range(0, 4)), md, 1'($urandom_range(0, 9) == 0));
            n = md ? $urandom_range(10, 120) : 2000;
            for (int c = 0; c < n; c++) begin
                @(posedge clk); #2;
                if (!m_active) break;
                bus.stop    = ($urandom_range(0, 99) == 0);
                bus.start   = ($urandom_range(0, 29) == 0);
                bus.f_start = N'($urandom);
                bus.f_stop  = N'($urandom);
                bus.f_step  = N'($urandom);
                bus.dwell   = DW'($urandom);
                bus.mode    = 1'($urandom);
            end
            bus.start = 1'b0;
            bus.stop  = 1'b0;
            chk($sformatf("rand_bound%0d", it), 64'(m_active && !md), 64'd0);
            @(posedge clk); #2 bus.stop = 1'b1;
            @(posedge clk); #2 bus.stop = 1'b0;
            repeat (2) @(posedge clk);
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
